// File: rtl/countdown_timer_pkg.sv
// Package for the countdown timer: FSM state type and default sizing.
//   state_t        IDLE / RUN / HOLD
//   CDT_WIDTH      default count width
//   CDT_RELOAD_RST default reload/count value after reset
package countdown_timer_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_t;

  localparam int              CDT_WIDTH      = 4;
  localparam logic [3:0]      CDT_RELOAD_RST = 4'd9;
endpackage

// File: rtl/countdown_timer_if.sv
// Control/status bundle of the countdown timer.
//   load, load_val     capture a new count and reload value
//   start, pause       run control
//   auto_reload        restart from the reload value at terminal count
//   count, busy, done  registered status
//   zero               combinational count == 0
// master drives control (bench / host), slave is the timer.
interface countdown_timer_if import countdown_timer_pkg::*; #(
  parameter int WIDTH = CDT_WIDTH
);
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             pause;
  logic             auto_reload;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             zero;

  modport master (
    output load, load_val, start, pause, auto_reload,
    input  count, busy, done, zero
  );

  modport slave (
    input  load, load_val, start, pause, auto_reload,
    output count, busy, done, zero
  );
endinterface

// File: rtl/countdown_timer_dcount.sv
// WIDTH-bit count register with load (priority), decrement and hold.
//   i_clk, i_rst_n  clock, async active-low reset (count -> RST_VAL)
//   i_load          o_count <= i_load_val
//   i_dec           o_count <= o_count - 1 (caller guarantees count != 0)
//   o_count         registered count
module dcount_core #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic [WIDTH-1:0] o_count
);
  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    r_count <= RST_VAL;
    else if (i_load) r_count <= i_load_val;
    else if (i_dec)  r_count <= r_count - WIDTH'(1);
  end

  assign o_count = r_count;
endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter timer: counts a programmed value to zero, pulses
// done for one cycle, then idles or auto-reloads.
//   clk, rst_n  clock, async active-low reset
//   bus         countdown_timer_if.slave (load/start/pause/auto_reload in,
//               count/busy/done/zero out)
// Input priority per edge: load > start > pause. In RUN a start on the same
// edge as pause keeps the timer running.
module countdown_timer import countdown_timer_pkg::*; #(
  parameter int               WIDTH      = CDT_WIDTH,
  parameter logic [WIDTH-1:0] RELOAD_RST = WIDTH'(CDT_RELOAD_RST)
) (
  input  logic              clk,
  input  logic              rst_n,
  countdown_timer_if.slave  bus
);
  state_t           r_state;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_reload;

  logic [WIDTH-1:0] w_count;
  logic             w_zero;
  logic             w_pause_take;
  logic             w_core_load;
  logic [WIDTH-1:0] w_core_val;
  logic             w_dec;

  assign w_zero       = (w_count == '0);
  // pause only takes effect while running, and loses to load and start
  assign w_pause_take = (r_state == RUN) && bus.pause && !bus.start && !bus.load;

  // count register control
  always_comb begin
    w_core_load = 1'b0;
    w_core_val  = bus.load_val;
    w_dec       = 1'b0;
    if (bus.load) begin
      w_core_load = 1'b1;
    end else if (r_state == RUN && !w_pause_take) begin
      if (!w_zero) begin
        w_dec = 1'b1;
      end else if (bus.auto_reload) begin
        // terminal edge: restart from the reload value
        w_core_load = 1'b1;
        w_core_val  = r_reload;
      end
    end
  end

  dcount_core #(.WIDTH(WIDTH), .RST_VAL(RELOAD_RST)) u_core (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_load     (w_core_load),
    .i_load_val (w_core_val),
    .i_dec      (w_dec),
    .o_count    (w_count)
  );

  // FSM, done pulse and reload register; busy tracks the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_reload <= RELOAD_RST;
    end else begin
      r_done <= 1'b0;
      if (bus.load) begin
        // abort without a done pulse
        r_reload <= bus.load_val;
        r_state  <= IDLE;
        r_busy   <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (bus.start) begin
              if (w_zero) begin
                r_done <= 1'b1;
              end else begin
                r_state <= RUN;
                r_busy  <= 1'b1;
              end
            end
          end
          RUN: begin
            if (w_pause_take) begin
              r_state <= HOLD;
            end else if (w_zero) begin
              r_done <= 1'b1;
              if (!bus.auto_reload) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
              end
            end
          end
          HOLD: begin
            if (bus.start) r_state <= RUN;
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.count = w_count;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.zero  = w_zero;
endmodule
